pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Pipeline control unit. Produces the hold_flag consumed by the pc/if_id/id_ex stage registers.
//  Merges stall requests from EX, CLINT, bus arbiter and JTAG halt into one hold level.
//  Forwards branch/jump redirects and enforces a multi-cycle flush of the front end after each jump.
//  Also provides a bus-hold watchdog and a stall-cycle counter.
// PARAMETERS
//  FLUSH_CYCLES  2    cycles Hold_Id is forced, counted from and including the jump cycle (>=1)
//  RIB_TIMEOUT   256  consecutive hold_flag_rib_i cycles that trigger bus_timeout_o (>=2)
// PORTS
//  clk                input   1   clock, all state on rising edge
//  rst                input   1   asynchronous, active-low reset (`RstEnable)
//  jump_flag_i        input   1   EX requests redirect this cycle
//  jump_addr_i        input   32  redirect target (`InstAddrBus)
//  hold_flag_ex_i     input   1   EX multi-cycle op busy (divider)
//  hold_flag_rib_i    input   1   bus arbiter grants bus to another master
//  hold_flag_clint_i  input   1   CLINT interrupt entry/exit in progress
//  jtag_halt_flag_i   input   1   debugger halt request (level)
//  hold_flag_o        output  3   merged hold level (`Hold_Flag_Bus)
//  jump_flag_o        output  1   redirect to pc_reg
//  jump_addr_o        output  32  redirect target to pc_reg
//  bus_timeout_o      output  1   one-cycle pulse, bus hold exceeded RIB_TIMEOUT
//  stall_cnt_o        output  32  cycles with hold_flag_o != `Hold_None
// BEHAVIOUR
//  Hold codes: `Hold_None=0, `Hold_Pc=1, `Hold_If=2, `Hold_Id=3; consumers act on hold_flag >= their level.
//  Reset (rst low, async): state RUN, flush_cnt=0, rib_cnt=0, bus_timeout_o=0, stall_cnt_o=0.
//   Combinational outputs during reset: hold_flag_o=`Hold_None, jump_flag_o=0, jump_addr_o=`ZeroWord.
//  Source levels: jump_flag_i, hold_flag_ex_i, hold_flag_clint_i, state FLUSH, state HALT -> `Hold_Id;
//   hold_flag_rib_i -> `Hold_Pc. hold_flag_o = maximum of all active levels, combinational, same cycle.
//  jump_flag_o = jump_flag_i, jump_addr_o = jump_addr_i, combinational in every state (no gating).
//   jump_addr_o = `ZeroWord when jump_flag_i = 0.
//  State machine (registered):
//   RUN   : jump_flag_i & FLUSH_CYCLES>1 -> FLUSH, flush_cnt <= FLUSH_CYCLES-1;
//           else jtag_halt_flag_i -> HALT.
//   FLUSH : flush_cnt decrements each cycle; jump_flag_i reloads flush_cnt to FLUSH_CYCLES-1
//           (restart, no merge). flush_cnt==1 & no new jump -> RUN, or HALT if jtag_halt_flag_i.
//   HALT  : stays while jtag_halt_flag_i; deassert -> RUN next cycle.
//           A jump in HALT is still forwarded but does not start FLUSH.
//  Priority when jump and halt request coincide in RUN: FLUSH wins; HALT is entered at flush end.
//  FLUSH_CYCLES==1: jump affects only its own cycle; state never leaves RUN because of a jump.
//  Watchdog: rib_cnt increments while hold_flag_rib_i=1, clears when 0, saturates at RIB_TIMEOUT.
//   bus_timeout_o = 1 for exactly the cycle after rib_cnt reaches RIB_TIMEOUT (registered).
//   It re-arms only after hold_flag_rib_i drops. No effect on hold_flag_o.
//  stall_cnt_o: +1 on each clock where hold_flag_o != 0. Wraps 0xFFFFFFFF -> 0.
//  Reset mid-FLUSH or mid-HALT: immediate return to RUN; pending flush is discarded.
// TESTING
//  jump_flag_i=1 for 1 cycle, addr 0x100, FLUSH_CYCLES=2 -> jump_flag_o=1, jump_addr_o=0x100
//   same cycle; hold_flag_o=3 for exactly 2 cycles, then 0; stall_cnt_o=2.
//  Jumps at cycles 0 and 1, FLUSH_CYCLES=3 -> hold_flag_o=3 at cycles 0..3, 0 at cycle 4.
//  hold_flag_rib_i=1 and hold_flag_ex_i=0 -> hold_flag_o=1; raise hold_flag_ex_i -> 3 same cycle.
//  hold_flag_rib_i held 300 cycles, RIB_TIMEOUT=256 -> exactly one bus_timeout_o pulse, at cycle 256.
//   Drop for 1 cycle, re-hold 256 cycles -> second pulse.
//  jtag_halt_flag_i and jump together in RUN -> hold=3 for FLUSH_CYCLES cycles, then HALT;
//   deassert halt -> hold=0 one cycle later.
//  Assert rst low mid-FLUSH, asynchronously -> hold_flag_o=0 and stall_cnt_o=0 before next edge;
//   RUN after release.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl
//  Brief    : Pipeline hold merger, jump redirect, post-jump front-end flush,
//             bus-hold watchdog and stall-cycle counter.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int RIB_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        hold_flag_clint_i,
    input  logic        jtag_halt_flag_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_timeout_o,
    output logic [31:0] stall_cnt_o
);

    localparam logic [2:0] C_HOLD_NONE = 3'd0;
    localparam logic [2:0] C_HOLD_PC   = 3'd1;
    localparam logic [2:0] C_HOLD_ID   = 3'd3;

    localparam logic [1:0] C_ST_RUN   = 2'd0;
    localparam logic [1:0] C_ST_FLUSH = 2'd1;
    localparam logic [1:0] C_ST_HALT  = 2'd2;

    localparam int C_FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int C_RCW = $clog2(RIB_TIMEOUT + 1);

    localparam logic [C_FCW-1:0] C_FLUSH_LOAD = C_FCW'(FLUSH_CYCLES - 1);
    localparam logic [C_FCW-1:0] C_FLUSH_ONE  = C_FCW'(1);
    localparam logic [C_RCW-1:0] C_RIB_MAX    = C_RCW'(RIB_TIMEOUT);
    localparam logic [C_RCW-1:0] C_RIB_LAST   = C_RCW'(RIB_TIMEOUT - 1);
    localparam logic [C_RCW-1:0] C_RIB_ONE    = C_RCW'(1);
    localparam bit               C_FLUSH_EN   = (FLUSH_CYCLES > 1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [C_FCW-1:0] r_flush_cnt;
    logic [C_FCW-1:0] w_flush_cnt_nxt;
    logic [C_RCW-1:0] r_rib_cnt;
    logic             r_bus_timeout;
    logic [31:0]      r_stall_cnt;
    logic             w_hold_id;

    // Outputs are forced quiet while reset is held, independent of the clock.
    always_comb begin
        w_hold_id = jump_flag_i | hold_flag_ex_i | hold_flag_clint_i |
                    (r_state == C_ST_FLUSH) | (r_state == C_ST_HALT);
        hold_flag_o = C_HOLD_NONE;
        if (rst) begin
            if (w_hold_id)
                hold_flag_o = C_HOLD_ID;
            else if (hold_flag_rib_i)
                hold_flag_o = C_HOLD_PC;
        end
    end

    assign jump_flag_o   = rst & jump_flag_i;
    assign jump_addr_o   = (rst & jump_flag_i) ? jump_addr_i : 32'h0;
    assign bus_timeout_o = r_bus_timeout;
    assign stall_cnt_o   = r_stall_cnt;

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            C_ST_RUN: begin
                if (jump_flag_i && C_FLUSH_EN) begin
                    w_state_nxt     = C_ST_FLUSH;
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                end else if (jtag_halt_flag_i) begin
                    w_state_nxt = C_ST_HALT;
                end
            end
            C_ST_FLUSH: begin
                // A new jump restarts the flush window rather than extending it.
                if (jump_flag_i) begin
                    w_flush_cnt_nxt = C_FLUSH_LOAD;
                end else if (r_flush_cnt == C_FLUSH_ONE) begin
                    w_flush_cnt_nxt = '0;
                    w_state_nxt     = jtag_halt_flag_i ? C_ST_HALT : C_ST_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - C_FLUSH_ONE;
                end
            end
            C_ST_HALT: begin
                if (!jtag_halt_flag_i)
                    w_state_nxt = C_ST_RUN;
            end
            default: begin
                w_state_nxt     = C_ST_RUN;
                w_flush_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= C_ST_RUN;
            r_flush_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Pulse fires on the edge the counter reaches the limit; saturation keeps it single.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rib_cnt     <= '0;
            r_bus_timeout <= 1'b0;
        end else begin
            r_bus_timeout <= hold_flag_rib_i && (r_rib_cnt == C_RIB_LAST);
            if (!hold_flag_rib_i)
                r_rib_cnt <= '0;
            else if (r_rib_cnt != C_RIB_MAX)
                r_rib_cnt <= r_rib_cnt + C_RIB_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= 32'h0;
        else if (hold_flag_o != C_HOLD_NONE)
            r_stall_cnt <= r_stall_cnt + 32'h1;
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_ctrl
//  Brief    : Self-checking bench for pipe_ctrl against a cycle-indexed model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_ctrl;

    localparam int FC = 3;
    localparam int RT = 256;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic        hold_flag_ex_i;
    logic        hold_flag_rib_i;
    logic        hold_flag_clint_i;
    logic        jtag_halt_flag_i;
    logic [2:0]  hold_flag_o;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic        bus_timeout_o;
    logic [31:0] stall_cnt_o;

    int errors = 0;
    int checks = 0;

    // Model state: cycle index, last cycle covered by a flush, halt mode,
    // length of the current unbroken bus-hold run, expected stall count.
    int          t;
    int          flush_last;
    bit          halted;
    int          run_len;
    logic [31:0] exp_stall;

    pipe_ctrl #(.FLUSH_CYCLES(FC), .RIB_TIMEOUT(RT)) dut (
        .clk               (clk),
        .rst               (rst),
        .jump_flag_i       (jump_flag_i),
        .jump_addr_i       (jump_addr_i),
        .hold_flag_ex_i    (hold_flag_ex_i),
        .hold_flag_rib_i   (hold_flag_rib_i),
        .hold_flag_clint_i (hold_flag_clint_i),
        .jtag_halt_flag_i  (jtag_halt_flag_i),
        .hold_flag_o       (hold_flag_o),
        .jump_flag_o       (jump_flag_o),
        .jump_addr_o       (jump_addr_o),
        .bus_timeout_o     (bus_timeout_o),
        .stall_cnt_o       (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t          = 0;
        flush_last = -1;
        halted     = 1'b0;
        run_len    = 0;
        exp_stall  = 32'h0;
    endtask

    // Drive one cycle of inputs, check at the falling edge, advance the model.
    task automatic step(input logic j, input logic [31:0] a, input logic ex,
                        input logic rb, input logic cl, input logic hl);
        logic [2:0] eh;
        bit         flushing;
        jump_flag_i       = j;
        jump_addr_i       = a;
        hold_flag_ex_i    = ex;
        hold_flag_rib_i   = rb;
        hold_flag_clint_i = cl;
        jtag_halt_flag_i  = hl;
        @(negedge clk);
        flushing = (t <= flush_last);
        eh = (j || ex || cl || flushing || halted) ? 3'd3 : (rb ? 3'd1 : 3'd0);
        check("hold_flag", {29'b0, hold_flag_o}, {29'b0, eh});
        check("jump_flag", {31'b0, jump_flag_o}, {31'b0, j});
        check("jump_addr", jump_addr_o, j ? a : 32'h0);
        check("bus_timeout", {31'b0, bus_timeout_o}, {31'b0, (run_len == RT)});
        check("stall_cnt", stall_cnt_o, exp_stall);
        @(posedge clk);
        if (eh != 3'd0) exp_stall = exp_stall + 32'h1;
        run_len = rb ? run_len + 1 : 0;
        if (halted) begin
            if (!hl) halted = 1'b0;
        end else if (j && FC > 1) begin
            flush_last = t + FC - 1;
        end else if (t >= flush_last && hl) begin
            halted = 1'b1;
        end
        t++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic rb_s, hl_s;
        rst               = 1'b0;
        jump_flag_i       = 1'b1;
        jump_addr_i       = 32'hDEAD_BEEF;
        hold_flag_ex_i    = 1'b1;
        hold_flag_rib_i   = 1'b1;
        hold_flag_clint_i = 1'b1;
        jtag_halt_flag_i  = 1'b1;
        model_reset();
        #12;
        check("rst_hold", {29'b0, hold_flag_o}, 32'h0);
        check("rst_jflag", {31'b0, jump_flag_o}, 32'h0);
        check("rst_jaddr", jump_addr_o, 32'h0);
        check("rst_timeout", {31'b0, bus_timeout_o}, 32'h0);
        check("rst_stall", stall_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();

        // Single jump, then back-to-back jumps restarting the flush.
        step(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(5);

        // Bus hold alone, then EX busy on top.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Watchdog: long hold, one-cycle drop, exact-length re-hold.
        for (int i = 0; i < 300; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < RT; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // Jump and halt together: flush first, then halt until released.
        step(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < FC + 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h340, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        // Randomized traffic with sticky bus-hold and halt levels.
        rb_s = 1'b0;
        hl_s = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rb_s = ~rb_s;
            if ($urandom_range(23) == 0) hl_s = ~hl_s;
            step(($urandom_range(4) == 0), $urandom, ($urandom_range(7) == 0),
                 rb_s, ($urandom_range(9) == 0), hl_s);
        end
        idle(FC + 2);

        // Asynchronous reset in the middle of a flush.
        step(1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_hold", {29'b0, hold_flag_o}, 32'h0);
        check("async_rst_stall", stall_cnt_o, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
